// File: rtl/convolution_ctrl.sv
// -----------------------------------------------------------------------------
// convolution_ctrl
//
// Sequencer for a 1-D convolution datapath computing z[k] = sum_i x[i]*h[k-i].
// For each output index k it sweeps i over 0..Nx-1, issues x/h reads only for
// the (i, k-i) pairs that land inside h, lets the MAC absorb the last product,
// then writes the accumulated z[k] and advances k.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start              single-cycle request, honoured only while idle
//   size_x, size_y     lengths Nx and Ny, latched at start acceptance
//   addr_x, addr_y     x / h read addresses (i and k-i), valid with rd_en
//   rd_en              read strobe to the x / h memories (1-cycle read latency)
//   mac_en             accumulate current read data (rd_en delayed one cycle)
//   mac_clr            clear the accumulator
//   enh                one-cycle pulse whenever k advances
//   k_idx              current outer index k
//   wr_en, addr_z      write the accumulator into z memory at address k
//   busy               high from start acceptance until completion
//   done               one-cycle completion pulse
//   err                one-cycle pulse together with done when a size is zero
// -----------------------------------------------------------------------------
module convolution_ctrl #(
    parameter int DATA_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] size_x,
    input  logic [DATA_WIDTH-1:0] size_y,
    output logic [DATA_WIDTH-1:0] addr_x,
    output logic [DATA_WIDTH-1:0] addr_y,
    output logic                  rd_en,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic                  enh,
    output logic [DATA_WIDTH:0]   k_idx,
    output logic                  wr_en,
    output logic [DATA_WIDTH:0]   addr_z,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int KW = DATA_WIDTH + 1;
    localparam int JW = DATA_WIDTH + 2;

    localparam logic [DATA_WIDTH-1:0] I_ONE = 1;
    localparam logic [KW-1:0]         K_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   nx_q, ny_q;
    logic [KW-1:0]           nz_q;
    logic [KW-1:0]           k_q;
    logic [DATA_WIDTH-1:0]   i_q;
    logic [DATA_WIDTH-1:0]   addr_x_q, addr_y_q;
    logic                    mac_en_q;

    // j = k - i evaluated with one extra bit so that negative values are
    // recognisable through the sign bit.
    logic [JW-1:0]           j_w;
    logic                    j_in_range;
    logic                    last_i;
    logic                    last_k;

    assign j_w        = {1'b0, k_q} - {2'b00, i_q};
    assign j_in_range = !j_w[JW-1] && (j_w < {2'b00, ny_q});
    assign last_i     = (i_q == nx_q - I_ONE);
    assign last_k     = (k_q == nz_q - K_ONE);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((size_x == '0) || (size_y == '0)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_ERR:   state_d = S_IDLE;
            S_LOAD:  state_d = S_ISSUE;
            S_ISSUE: state_d = last_i ? S_DRAIN : S_ISSUE;
            // One idle cycle lets mac_en for the final read reach the MAC
            // before the accumulator is sampled.
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: state_d = last_k ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        rd_en   = 1'b0;
        mac_clr = 1'b0;
        wr_en   = 1'b0;
        enh     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            S_LOAD: begin
                busy    = 1'b1;
                mac_clr = 1'b1;
            end
            S_ISSUE: begin
                busy  = 1'b1;
                rd_en = j_in_range;
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_WRITE: begin
                // The write samples the accumulator before the clear lands.
                busy    = 1'b1;
                wr_en   = 1'b1;
                mac_clr = 1'b1;
                enh     = !last_k;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
        // Addresses only move on real reads; skipped pairs keep the last one.
        addr_x = rd_en ? i_q : addr_x_q;
        addr_y = rd_en ? j_w[DATA_WIDTH-1:0] : addr_y_q;
    end

    assign mac_en = mac_en_q;
    assign k_idx  = k_q;
    assign addr_z = k_q;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nx_q     <= '0;
            ny_q     <= '0;
            nz_q     <= '0;
            k_q      <= '0;
            i_q      <= '0;
            addr_x_q <= '0;
            addr_y_q <= '0;
            mac_en_q <= 1'b0;
        end else begin
            mac_en_q <= rd_en;
            addr_x_q <= addr_x;
            addr_y_q <= addr_y;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        nx_q <= size_x;
                        ny_q <= size_y;
                        nz_q <= {1'b0, size_x} + {1'b0, size_y} - K_ONE;
                    end
                end
                S_LOAD: begin
                    k_q <= '0;
                    i_q <= '0;
                end
                S_ISSUE: begin
                    i_q <= i_q + I_ONE;
                end
                S_WRITE: begin
                    i_q <= '0;
                    if (!last_k) begin
                        k_q <= k_q + K_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_convolution_ctrl.sv
module tb_convolution_ctrl;

    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] size_x = '0;
    logic [DW-1:0] size_y = '0;
    logic [DW-1:0] addr_x, addr_y;
    logic          rd_en, mac_en, mac_clr, enh, wr_en, busy, done, err;
    logic [DW:0]   k_idx, addr_z;

    convolution_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .size_x  (size_x),
        .size_y  (size_y),
        .addr_x  (addr_x),
        .addr_y  (addr_y),
        .rd_en   (rd_en),
        .mac_en  (mac_en),
        .mac_clr (mac_clr),
        .enh     (enh),
        .k_idx   (k_idx),
        .wr_en   (wr_en),
        .addr_z  (addr_z),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Behavioural x/h memories, MAC and z memory.
    int unsigned x_mem [32];
    int unsigned h_mem [32];
    int unsigned z_mem [64];
    int unsigned x_rd, h_rd, acc;

    always @(posedge clk) begin
        if (rd_en) begin
            x_rd <= x_mem[addr_x];
            h_rd <= h_mem[addr_y];
        end
        if (mac_clr)     acc <= 0;
        else if (mac_en) acc <= acc + x_rd * h_rd;
        if (wr_en) z_mem[addr_z] <= acc;
    end

    // Free-running monitor: counters only grow; runs look at deltas.
    int rd_cnt = 0, wr_cnt = 0, enh_cnt = 0, busy_cnt = 0;
    int done_cnt = 0, err_cnt = 0, viol_cnt = 0, rd_since_wr = 0;
    int rdq[$];
    int wq[$];
    logic prev_rd = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_rd     = 1'b0;
            rd_since_wr = 0;
        end else begin
            if (rd_en) begin
                rd_cnt++;
                rd_since_wr++;
                if (addr_x >= size_x || addr_y >= size_y) viol_cnt++;
            end
            if (mac_en !== prev_rd) viol_cnt++;
            prev_rd = rd_en;
            if ((rd_en || mac_en || wr_en || enh) && !busy) viol_cnt++;
            if (wr_en) begin
                if (addr_z !== k_idx) viol_cnt++;
                rdq.push_back(rd_since_wr);
                wq.push_back(int'(addr_z));
                rd_since_wr = 0;
                wr_cnt++;
            end
            if (enh)  enh_cnt++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                if (!done) viol_cnt++;
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic fill_random();
        for (int a = 0; a < 32; a++) begin
            x_mem[a] = $urandom_range(0, 255);
            h_mem[a] = $urandom_range(0, 255);
        end
    endtask

    task automatic fill_fixed();
        fill_random();
        x_mem[0] = 1; x_mem[1] = 2; x_mem[2] = 3;
        h_mem[0] = 1; h_mem[1] = 1;
    endtask

    // Runs one convolution and checks it against the textbook definition.
    task automatic do_run(input string tag, input int nx, input int ny, input int mid_start,
                          input int e_lat, input int e_rd, input int e_wr,
                          input int e_enh, input int e_err);
        int b_rd, b_wr, b_enh, b_busy, b_done, b_err, b_viol, b_q;
        int lat, nz, cnt;
        int unsigned sum;
        b_rd = rd_cnt; b_wr = wr_cnt; b_enh = enh_cnt; b_busy = busy_cnt;
        b_done = done_cnt; b_err = err_cnt; b_viol = viol_cnt; b_q = rdq.size();

        @(posedge clk); #1;
        size_x = DW'(nx);
        size_y = DW'(ny);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 5000) begin
            @(posedge clk); #1;
            lat++;
            start = (lat == mid_start);
        end
        start = 1'b0;
        @(posedge clk); #1;

        $display("run %s: Nx=%0d Ny=%0d latency=%0d rd=%0d wr=%0d enh=%0d err=%0d",
                 tag, nx, ny, lat, rd_cnt - b_rd, wr_cnt - b_wr, enh_cnt - b_enh,
                 err_cnt - b_err);
        chk({tag, " latency"}, lat, e_lat);
        chk({tag, " rd_en count"}, rd_cnt - b_rd, e_rd);
        chk({tag, " wr_en count"}, wr_cnt - b_wr, e_wr);
        chk({tag, " enh count"}, enh_cnt - b_enh, e_enh);
        chk({tag, " err pulses"}, err_cnt - b_err, e_err);
        chk({tag, " done pulses"}, done_cnt - b_done, 1);
        chk({tag, " busy cycles"}, busy_cnt - b_busy, (e_err != 0) ? 0 : e_lat - 1);
        chk({tag, " protocol violations"}, viol_cnt - b_viol, 0);

        if (e_err == 0) begin
            nz = nx + ny - 1;
            chk({tag, " final k_idx"}, int'(k_idx), nz - 1);
            for (int k = 0; k < nz; k++) begin
                sum = 0;
                cnt = 0;
                for (int i = 0; i < nx; i++) begin
                    if (k - i >= 0 && k - i < ny) begin
                        sum += x_mem[i] * h_mem[k - i];
                        cnt++;
                    end
                end
                chk($sformatf("%s z[%0d]", tag, k), int'(z_mem[k]), int'(sum));
                if (b_q + k < rdq.size()) begin
                    chk($sformatf("%s reads for k=%0d", tag, k), rdq[b_q + k], cnt);
                    chk($sformatf("%s write addr #%0d", tag, k), wq[b_q + k], k);
                end
            end
        end
    endtask

    task automatic chk_fixed_z(input string tag);
        int zc[4];
        zc[0] = 1; zc[1] = 3; zc[2] = 5; zc[3] = 3;
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s fixed z[%0d]", tag, k), int'(z_mem[k]), zc[k]);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " outputs"},
            int'({addr_x, addr_y, rd_en, mac_en, mac_clr, enh, k_idx, wr_en,
                  addr_z, busy, done, err}), 0);
    endtask

    typedef struct {
        int nx;
        int ny;
        int lat;
        int rd;
        int wr;
        int enh;
        int err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{3,  2,  22,   6,   4,  3,  0};
        vecs[1] = '{1,  1,  5,    1,   1,  0,  0};
        vecs[2] = '{31, 31, 2015, 961, 61, 60, 0};
        vecs[3] = '{0,  5,  1,    0,   0,  0,  1};
        vecs[4] = '{4,  0,  1,    0,   0,  0,  1};
        vecs[5] = '{2,  5,  26,   10,  6,  5,  0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed scenario with known data.
        fill_fixed();
        do_run("basic", 3, 2, 0, 22, 6, 4, 3, 0);
        chk_fixed_z("basic");

        // Table of size combinations including the edges and error cases.
        for (int v = 0; v < 6; v++) begin
            fill_random();
            do_run($sformatf("vec%0d", v), vecs[v].nx, vecs[v].ny, 0,
                   vecs[v].lat, vecs[v].rd, vecs[v].wr, vecs[v].enh, vecs[v].err);
        end

        // A start pulse in the middle of a run must be ignored.
        fill_fixed();
        do_run("midstart", 3, 2, 7, 22, 6, 4, 3, 0);
        chk_fixed_z("midstart");
        fill_random();
        do_run("after_mid", 2, 3, 0, 1 + 4 * 4 + 1, 6, 4, 3, 0);

        // Reset while issuing reads for k=2.
        fill_fixed();
        @(posedge clk); #1;
        size_x = 5'd3;
        size_y = 5'd2;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (k_idx != 6'd2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached k=2", int'(k_idx), 2);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk_outputs_zero("async reset");
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("held reset");
        rstn = 1'b1;
        do_run("post_reset", 3, 2, 0, 22, 6, 4, 3, 0);
        chk_fixed_z("post_reset");

        // Randomized sizes against the reference model.
        for (int r = 0; r < 8; r++) begin
            int nx, ny, nz;
            nx = $urandom_range(1, 12);
            ny = $urandom_range(1, 12);
            nz = nx + ny - 1;
            fill_random();
            do_run($sformatf("rand%0d", r), nx, ny, 0,
                   1 + nz * (nx + 2) + 1, nx * ny, nz, nz - 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/convolution_ctrl.md
Name: convolution_ctrl

Overview:
Control unit for the 1-D convolution datapath, z[k] = sum over i of x[i]*h[k-i]. Sits directly upstream of the k-index accumulator and the MAC/result-memory stage. It sequences the outer index k and the inner index i, generates x/h read addresses, and drives the MAC enable/clear controls. It pulses the k-advance enable that the index accumulator consumes, and writes each z[k] through a start/busy/done handshake.

Parameters:
DATA_WIDTH, 5, width of the x/h indices and size inputs; the z index and k are DATA_WIDTH+1 bits wide.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle request; accepted only in IDLE
size_x  in  DATA_WIDTH  length Nx of x (1..2^DATA_WIDTH-1)
size_y  in  DATA_WIDTH  length Ny of h (1..2^DATA_WIDTH-1)
addr_x  out  DATA_WIDTH  x memory read address (i)
addr_y  out  DATA_WIDTH  h memory read address (k-i)
rd_en  out  1  read strobe to x/h memories (1-cycle synchronous read)
mac_en  out  1  accumulate the product of the current read data; rd_en delayed 1 cycle
mac_clr  out  1  clear the accumulator
enh  out  1  one-cycle pulse when k advances; drives the k-index accumulator
k_idx  out  DATA_WIDTH+1  current outer index k
wr_en  out  1  write accumulator to z memory
addr_z  out  DATA_WIDTH+1  z write address (= k)
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done when Nx=0 or Ny=0

Behaviour:
- Reset (async, rstn=0): state=IDLE; all outputs 0; k=0, i=0, latched sizes 0. Reset mid-run aborts immediately, with no further rd_en, mac_en or wr_en.
- Sizes are latched when start is accepted. Nz = Nx+Ny-1, computed at DATA_WIDTH+1 bits (no overflow; max 61 at the default width).
- start while busy=1 is ignored.
- IDLE:
  - start with both sizes nonzero -> LOAD.
  - start with either size 0 -> ERR.
- ERR: done=1 and err=1 for one cycle -> IDLE. No reads, MAC activity or writes.
- LOAD: busy=1, mac_clr=1, k=0, i=0 -> ISSUE.
- ISSUE: one cycle per i, for i = 0..Nx-1.
  - j = k-i, computed signed at DATA_WIDTH+2 bits.
  - If 0 <= j < Ny: rd_en=1, addr_x=i, addr_y=j[DATA_WIDTH-1:0].
  - Otherwise: rd_en=0, and addr_x/addr_y hold their previous values.
  - i increments each cycle. After i=Nx-1 -> DRAIN.
- DRAIN: one cycle, so that mac_en for the last read lands.
- mac_en is a registered copy of rd_en, exactly 1 cycle later, including across the ISSUE->DRAIN boundary.
- WRITE: wr_en=1, addr_z=k, mac_clr=1 in the same cycle. z is sampled before the clear takes effect.
  - If k = Nz-1 -> DONE.
  - Otherwise: k++, enh=1 for this cycle, i=0 -> ISSUE.
- DONE: done=1 for one cycle, busy drops to 0 in the same cycle -> IDLE. k_idx holds its final value until the next LOAD.
- Latency from start acceptance to done: 1 + Nz*(Nx+2) + 1 cycles.
- Totals per run:
  - rd_en pulses = Nx*Ny
  - wr_en pulses = Nz
  - enh pulses = Nz-1
- k_idx always equals addr_z whenever wr_en=1.
- rd_en, mac_en, wr_en and enh are never asserted outside busy.

Test Plan:
- Nx=3, Ny=2, x={1,2,3}, h={1,1}, behavioural MAC/memories:
  - z = {1,3,5,3}
  - done exactly 22 cycles after start
  - rd_en counts per k: 1, 2, 2, 1
  - enh pulses: 3
- Nx=1, Ny=1 -> one rd_en (addr_x=0, addr_y=0), one wr_en at addr_z=0, done 5 cycles after start, zero enh pulses.
- Nx=31, Ny=31 -> 961 rd_en, 61 wr_en with addr_z 0..60, final k_idx=60, no address wrap, done after 1+61*33+1 = 2015 cycles.
- size_x=0 -> err and done high for one cycle in the cycle after start; no rd_en/wr_en; busy stays 0.
- start pulsed mid-run (Nx=3, Ny=2) -> ignored; response identical to the first scenario; a new start after done runs normally.
- rstn asserted during ISSUE of k=2 -> all outputs 0 immediately; a fresh start afterwards reproduces the first scenario exactly.
